// File: rtl/issue_rf_read_pkg.sv
// Shared widths for the register-read stage between the reservation station and EX.
// Physical-register and PC widths are fixed machine-wide; the rest are per-instance defaults.
package issue_rf_read_pkg;

    localparam int DEF_DW                = 64;
    localparam int DEF_P_ROB_DEPTH       = 4;
    localparam int DEF_P_COMMIT_WIDTH    = 1;
    localparam int DEF_UOP_W             = 32;
    localparam int PRF_AW                = 6;
    localparam int PC_W                  = 32;

endpackage

// File: rtl/issue_rf_read_if.sv
// Valid/ready channel carrying an operand-complete uop from the register-read stage to EX.
interface issue_rf_read_if
    import issue_rf_read_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int ROB_W  = DEF_P_ROB_DEPTH,
    parameter int BANK_W = DEF_P_COMMIT_WIDTH,
    parameter int UW     = DEF_UOP_W
) ();

    logic              ex_valid;
    logic              ex_ready;
    logic [UW-1:0]     ex_uop;
    logic [PC_W-1:0]   ex_pc;
    logic [DW-1:0]     ex_imm;
    logic [PRF_AW-1:0] ex_prd;
    logic              ex_prd_we;
    logic [ROB_W-1:0]  ex_rob_id;
    logic [BANK_W-1:0] ex_rob_bank;
    logic [DW-1:0]     ex_opnd1;
    logic [DW-1:0]     ex_opnd2;

    modport master (
        output ex_valid, ex_uop, ex_pc, ex_imm, ex_prd, ex_prd_we,
               ex_rob_id, ex_rob_bank, ex_opnd1, ex_opnd2,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_uop, ex_pc, ex_imm, ex_prd, ex_prd_we,
               ex_rob_id, ex_rob_bank, ex_opnd1, ex_opnd2,
        output ex_ready
    );

endinterface

// File: rtl/issue_opnd_byp.sv
// Resolves one source operand in S1: PRF/held base, pop-cycle writeback overlay,
// live writeback overlay (highest priority), then zeroing of unread sources.
module issue_opnd_byp
    import issue_rf_read_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic              fresh,
    input  logic [DW-1:0]     prf_rdat,
    input  logic [DW-1:0]     opnd_q,
    input  logic              re,
    input  logic [PRF_AW-1:0] prs,
    input  logic              lbyp_we,
    input  logic [PRF_AW-1:0] lbyp_prd,
    input  logic [DW-1:0]     lbyp_dat,
    input  logic              byp_we,
    input  logic [PRF_AW-1:0] byp_prd,
    input  logic [DW-1:0]     byp_dat,
    output logic [DW-1:0]     opnd
);

    always_comb begin
        opnd = fresh ? prf_rdat : opnd_q;
        if (lbyp_we && (lbyp_prd == prs)) begin
            opnd = lbyp_dat;
        end
        if (byp_we && (byp_prd == prs)) begin
            opnd = byp_dat;
        end
        if (!re) begin
            opnd = '0;
        end
    end

endmodule

// File: rtl/issue_rf_read.sv
// Register-read stage: pops a uop from the RS, reads the synchronous PRF with writeback
// bypass, and hands an operand-complete uop to EX through a two-stage valid/ready pipe.
module issue_rf_read
    import issue_rf_read_pkg::*;
#(
    parameter int CONFIG_DW             = DEF_DW,
    parameter int CONFIG_P_ROB_DEPTH    = DEF_P_ROB_DEPTH,
    parameter int CONFIG_P_COMMIT_WIDTH = DEF_P_COMMIT_WIDTH,
    parameter int UOP_W                 = DEF_UOP_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             ro_valid,
    output logic                             ro_rs_pop,
    input  logic [UOP_W-1:0]                 ro_uop,
    input  logic [PC_W-1:0]                  ro_pc,
    input  logic [CONFIG_DW-1:0]             ro_imm,
    input  logic [PRF_AW-1:0]                ro_prs1,
    input  logic [PRF_AW-1:0]                ro_prs2,
    input  logic                             ro_prs1_re,
    input  logic                             ro_prs2_re,
    input  logic [PRF_AW-1:0]                ro_prd,
    input  logic                             ro_prd_we,
    input  logic [CONFIG_P_ROB_DEPTH-1:0]    ro_rob_id,
    input  logic [CONFIG_P_COMMIT_WIDTH-1:0] ro_rob_bank,
    output logic                             prf_re,
    output logic [PRF_AW-1:0]                prf_raddr1,
    output logic [PRF_AW-1:0]                prf_raddr2,
    input  logic [CONFIG_DW-1:0]             prf_rdat1,
    input  logic [CONFIG_DW-1:0]             prf_rdat2,
    input  logic                             byp_we,
    input  logic [PRF_AW-1:0]                byp_prd,
    input  logic [CONFIG_DW-1:0]             byp_dat,
    issue_rf_read_if.master                  ex
);

    localparam int DW  = CONFIG_DW;
    localparam int RW  = CONFIG_P_ROB_DEPTH;
    localparam int BW  = CONFIG_P_COMMIT_WIDTH;

    logic s2_rdy;
    logic s1_rdy;
    logic pop;

    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    logic s1_fresh_q, s1_fresh_d;
    logic s1_lbyp_we_q, s1_lbyp_we_d;

    logic [UOP_W-1:0]  s1_uop_q, s1_uop_d, s2_uop_q, s2_uop_d;
    logic [PC_W-1:0]   s1_pc_q, s1_pc_d, s2_pc_q, s2_pc_d;
    logic [DW-1:0]     s1_imm_q, s1_imm_d, s2_imm_q, s2_imm_d;
    logic [PRF_AW-1:0] s1_prd_q, s1_prd_d, s2_prd_q, s2_prd_d;
    logic              s1_prd_we_q, s1_prd_we_d, s2_prd_we_q, s2_prd_we_d;
    logic [RW-1:0]     s1_rob_id_q, s1_rob_id_d, s2_rob_id_q, s2_rob_id_d;
    logic [BW-1:0]     s1_rob_bank_q, s1_rob_bank_d, s2_rob_bank_q, s2_rob_bank_d;
    logic [PRF_AW-1:0] s1_prs1_q, s1_prs1_d, s1_prs2_q, s1_prs2_d;
    logic              s1_re1_q, s1_re1_d, s1_re2_q, s1_re2_d;
    logic [PRF_AW-1:0] s1_lbyp_prd_q, s1_lbyp_prd_d;
    logic [DW-1:0]     s1_lbyp_dat_q, s1_lbyp_dat_d;
    logic [DW-1:0]     s1_opnd1_q, s1_opnd1_d, s1_opnd2_q, s1_opnd2_d;
    logic [DW-1:0]     s2_opnd1_q, s2_opnd1_d, s2_opnd2_q, s2_opnd2_d;
    logic [DW-1:0]     s1_view1, s1_view2;

    assign s2_rdy     = ~s2_vld_q | ex.ex_ready;
    assign s1_rdy     = ~s1_vld_q | s2_rdy;
    assign pop        = ro_valid & s1_rdy & ~flush;
    assign ro_rs_pop  = pop;
    assign prf_re     = pop;
    assign prf_raddr1 = ro_prs1;
    assign prf_raddr2 = ro_prs2;

    // The latched pop-cycle writeback only matters in the fresh cycle; after that it is folded into s1_opnd_q.
    issue_opnd_byp #(.DW(DW)) u_byp1 (
        .fresh    (s1_fresh_q),
        .prf_rdat (prf_rdat1),
        .opnd_q   (s1_opnd1_q),
        .re       (s1_re1_q),
        .prs      (s1_prs1_q),
        .lbyp_we  (s1_lbyp_we_q & s1_fresh_q),
        .lbyp_prd (s1_lbyp_prd_q),
        .lbyp_dat (s1_lbyp_dat_q),
        .byp_we   (byp_we),
        .byp_prd  (byp_prd),
        .byp_dat  (byp_dat),
        .opnd     (s1_view1)
    );

    issue_opnd_byp #(.DW(DW)) u_byp2 (
        .fresh    (s1_fresh_q),
        .prf_rdat (prf_rdat2),
        .opnd_q   (s1_opnd2_q),
        .re       (s1_re2_q),
        .prs      (s1_prs2_q),
        .lbyp_we  (s1_lbyp_we_q & s1_fresh_q),
        .lbyp_prd (s1_lbyp_prd_q),
        .lbyp_dat (s1_lbyp_dat_q),
        .byp_we   (byp_we),
        .byp_prd  (byp_prd),
        .byp_dat  (byp_dat),
        .opnd     (s1_view2)
    );

    always_comb begin
        s1_vld_d     = flush ? 1'b0 : (pop ? 1'b1 : (s2_rdy ? 1'b0 : s1_vld_q));
        s2_vld_d     = flush ? 1'b0 : (s2_rdy ? s1_vld_q : s2_vld_q);
        s1_fresh_d   = pop;
        s1_lbyp_we_d = pop & byp_we;
    end

    always_comb begin
        s1_uop_d      = s1_uop_q;
        s1_pc_d       = s1_pc_q;
        s1_imm_d      = s1_imm_q;
        s1_prd_d      = s1_prd_q;
        s1_prd_we_d   = s1_prd_we_q;
        s1_rob_id_d   = s1_rob_id_q;
        s1_rob_bank_d = s1_rob_bank_q;
        s1_prs1_d     = s1_prs1_q;
        s1_prs2_d     = s1_prs2_q;
        s1_re1_d      = s1_re1_q;
        s1_re2_d      = s1_re2_q;
        s1_lbyp_prd_d = s1_lbyp_prd_q;
        s1_lbyp_dat_d = s1_lbyp_dat_q;
        s1_opnd1_d    = s1_opnd1_q;
        s1_opnd2_d    = s1_opnd2_q;
        s2_uop_d      = s2_uop_q;
        s2_pc_d       = s2_pc_q;
        s2_imm_d      = s2_imm_q;
        s2_prd_d      = s2_prd_q;
        s2_prd_we_d   = s2_prd_we_q;
        s2_rob_id_d   = s2_rob_id_q;
        s2_rob_bank_d = s2_rob_bank_q;
        s2_opnd1_d    = s2_opnd1_q;
        s2_opnd2_d    = s2_opnd2_q;

        if (pop) begin
            s1_uop_d      = ro_uop;
            s1_pc_d       = ro_pc;
            s1_imm_d      = ro_imm;
            s1_prd_d      = ro_prd;
            s1_prd_we_d   = ro_prd_we;
            s1_rob_id_d   = ro_rob_id;
            s1_rob_bank_d = ro_rob_bank;
            s1_prs1_d     = ro_prs1;
            s1_prs2_d     = ro_prs2;
            s1_re1_d      = ro_prs1_re;
            s1_re2_d      = ro_prs2_re;
            s1_lbyp_prd_d = byp_prd;
            s1_lbyp_dat_d = byp_dat;
        end

        // A stalled S1 keeps its resolved view so the one-shot PRF data survives.
        if (s1_vld_q && !s2_rdy) begin
            s1_opnd1_d = s1_view1;
            s1_opnd2_d = s1_view2;
        end

        if (s1_vld_q && s2_rdy) begin
            s2_uop_d      = s1_uop_q;
            s2_pc_d       = s1_pc_q;
            s2_imm_d      = s1_imm_q;
            s2_prd_d      = s1_prd_q;
            s2_prd_we_d   = s1_prd_we_q;
            s2_rob_id_d   = s1_rob_id_q;
            s2_rob_bank_d = s1_rob_bank_q;
            s2_opnd1_d    = s1_view1;
            s2_opnd2_d    = s1_view2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            s1_fresh_q   <= 1'b0;
            s1_lbyp_we_q <= 1'b0;
        end else begin
            s1_vld_q     <= s1_vld_d;
            s2_vld_q     <= s2_vld_d;
            s1_fresh_q   <= s1_fresh_d;
            s1_lbyp_we_q <= s1_lbyp_we_d;
        end
    end

    always_ff @(posedge clk) begin
        s1_uop_q      <= s1_uop_d;
        s1_pc_q       <= s1_pc_d;
        s1_imm_q      <= s1_imm_d;
        s1_prd_q      <= s1_prd_d;
        s1_prd_we_q   <= s1_prd_we_d;
        s1_rob_id_q   <= s1_rob_id_d;
        s1_rob_bank_q <= s1_rob_bank_d;
        s1_prs1_q     <= s1_prs1_d;
        s1_prs2_q     <= s1_prs2_d;
        s1_re1_q      <= s1_re1_d;
        s1_re2_q      <= s1_re2_d;
        s1_lbyp_prd_q <= s1_lbyp_prd_d;
        s1_lbyp_dat_q <= s1_lbyp_dat_d;
        s1_opnd1_q    <= s1_opnd1_d;
        s1_opnd2_q    <= s1_opnd2_d;
        s2_uop_q      <= s2_uop_d;
        s2_pc_q       <= s2_pc_d;
        s2_imm_q      <= s2_imm_d;
        s2_prd_q      <= s2_prd_d;
        s2_prd_we_q   <= s2_prd_we_d;
        s2_rob_id_q   <= s2_rob_id_d;
        s2_rob_bank_q <= s2_rob_bank_d;
        s2_opnd1_q    <= s2_opnd1_d;
        s2_opnd2_q    <= s2_opnd2_d;
    end

    assign ex.ex_valid    = s2_vld_q;
    assign ex.ex_uop      = s2_uop_q;
    assign ex.ex_pc       = s2_pc_q;
    assign ex.ex_imm      = s2_imm_q;
    assign ex.ex_prd      = s2_prd_q;
    assign ex.ex_prd_we   = s2_prd_we_q;
    assign ex.ex_rob_id   = s2_rob_id_q;
    assign ex.ex_rob_bank = s2_rob_bank_q;
    assign ex.ex_opnd1    = s2_opnd1_q;
    assign ex.ex_opnd2    = s2_opnd2_q;

endmodule
